// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter. Sends DATA_BITS (5..9) data bits LSB first,
// an optional even/odd parity bit and 1 or 2 stop bits. The bit period is
// programmable at runtime. A one-entry holding buffer behind a valid/ready
// handshake lets consecutive frames run with no idle gap on the line.
//
// Ports
//   i_Clock         single clock, rising edge
//   i_Rst_L         asynchronous active-low reset
//   i_Clks_Per_Bit  clock cycles per bit (0 treated as 1), latched per frame
//   i_Tx_Valid      i_Tx_Data is valid
//   i_Tx_Data       word to send, LSB first
//   o_Tx_Ready      holding buffer empty, a word can be accepted (registered)
//   o_Tx_Serial     registered serial line, idle high
//   o_Tx_Active     high while a frame is on the line
//   o_Tx_Done       one-cycle pulse after the last stop cycle of each frame
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, waiting for a transfer
// S_START  | start bit (line low) for N cycles
// S_DATA   | data bits, line = shift_reg[0], shift right per bit
// S_PARITY | parity bit for N cycles (only when PARITY is 1 or 2)
// S_STOP   | stop bit(s), line high; reload from buffer or input at end
module uart_tx_param #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
   input  logic                 i_Tx_Valid,
   input  logic [DATA_BITS-1:0] i_Tx_Data,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Done
);

   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
   localparam bit ODD_PAR = (PARITY == 2);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] hold_reg;
   logic                 par_bit;
   logic                 stop_idx;
   logic [DIV_W-1:0]     n_reg;
   logic [DIV_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     bit_idx;

   logic                 xfer;
   logic                 bit_end;
   logic                 frame_end;
   logic                 in_frame;
   logic [DIV_W-1:0]     n_in;

   assign xfer      = i_Tx_Valid & o_Tx_Ready;
   assign bit_end   = (bit_cnt == n_reg - DIV_W'(1));
   assign frame_end = (state == S_STOP) && bit_end && (stop_idx == LAST_STOP);
   assign in_frame  = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
   assign n_in      = (i_Clks_Per_Bit == '0) ? DIV_W'(1) : i_Clks_Per_Bit;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= S_IDLE;
         shift_reg   <= '0;
         hold_reg    <= '0;
         par_bit     <= 1'b0;
         stop_idx    <= 1'b0;
         n_reg       <= '0;
         bit_cnt     <= '0;
         bit_idx     <= '0;
         o_Tx_Ready  <= 1'b1;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         o_Tx_Done <= 1'b0;
         if (in_frame) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + DIV_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (xfer) begin
                  shift_reg   <= i_Tx_Data;
                  par_bit     <= (^i_Tx_Data) ^ ODD_PAR;
                  n_reg       <= n_in;
                  bit_cnt     <= '0;
                  state       <= S_START;
                  o_Tx_Serial <= 1'b0;
                  o_Tx_Active <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state       <= S_DATA;
                  bit_idx     <= '0;
                  o_Tx_Serial <= shift_reg[0];
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                  bit_idx   <= bit_idx + IDX_W'(1);
                  if (bit_idx == LAST_IDX) begin
                     if (HAS_PAR) begin
                        state       <= S_PARITY;
                        o_Tx_Serial <= par_bit;
                     end else begin
                        state       <= S_STOP;
                        stop_idx    <= 1'b0;
                        o_Tx_Serial <= 1'b1;
                     end
                  end else begin
                     o_Tx_Serial <= shift_reg[1];
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state       <= S_STOP;
                  stop_idx    <= 1'b0;
                  o_Tx_Serial <= 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (stop_idx != LAST_STOP) begin
                     stop_idx <= 1'b1;
                  end else begin
                     o_Tx_Done <= 1'b1;
                     if (!o_Tx_Ready) begin
                        // buffered word goes straight out: no idle gap
                        shift_reg   <= hold_reg;
                        par_bit     <= (^hold_reg) ^ ODD_PAR;
                        n_reg       <= n_in;
                        o_Tx_Ready  <= 1'b1;
                        state       <= S_START;
                        o_Tx_Serial <= 1'b0;
                     end else if (xfer) begin
                        shift_reg   <= i_Tx_Data;
                        par_bit     <= (^i_Tx_Data) ^ ODD_PAR;
                        n_reg       <= n_in;
                        state       <= S_START;
                        o_Tx_Serial <= 1'b0;
                     end else begin
                        state       <= S_IDLE;
                        o_Tx_Serial <= 1'b1;
                        o_Tx_Active <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state       <= S_IDLE;
               bit_cnt     <= '0;
               o_Tx_Serial <= 1'b1;
               o_Tx_Active <= 1'b0;
            end
         endcase

         // a mid-frame transfer parks in the buffer unless the final stop
         // edge consumes it directly
         if (xfer && in_frame && !frame_end) begin
            hold_reg   <= i_Tx_Data;
            o_Tx_Ready <= 1'b0;
         end
      end
   end

endmodule
